// File: rtl/can_bit_timing_pkg.sv
// Shared types and constants for the CAN bit-timing unit.
// Contents: bit-segment enum, bus level names, resync event codes,
//           and a helper that recognises a recessive->dominant transition.
package can_bit_timing_pkg;

  typedef enum logic [1:0] {
    SEG_SYNC  = 2'd0,
    SEG_TSEG1 = 2'd1,
    SEG_TSEG2 = 2'd2
  } can_seg_t;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  // resync_evt encodings
  localparam logic [1:0] RESYNC_NONE  = 2'b00;
  localparam logic [1:0] RESYNC_HARD  = 2'b01;
  localparam logic [1:0] RESYNC_LATE  = 2'b10;  // TSEG1 lengthened
  localparam logic [1:0] RESYNC_EARLY = 2'b11;  // TSEG2 shortened or bit restarted

  // Only recessive->dominant transitions carry timing information on CAN.
  function automatic logic is_fall(input logic prev, input logic cur);
    return (prev == RECESSIVE) && (cur == DOMINANT);
  endfunction

endpackage

// File: rtl/can_bit_timing_if.sv
// Bundle between the CAN RX pin / frame decoder and the bit-timing unit.
// Ports: rx, hard_sync_en (into the timing unit); sp, rx_bit, bit_start,
//        resync_evt (out of the timing unit). master = timing unit side.
interface can_bit_timing_if;
  logic       rx;
  logic       hard_sync_en;
  logic       sp;
  logic       rx_bit;
  logic       bit_start;
  logic [1:0] resync_evt;

  modport master (
    input  rx, hard_sync_en,
    output sp, rx_bit, bit_start, resync_evt
  );

  modport slave (
    output rx, hard_sync_en,
    input  sp, rx_bit, bit_start, resync_evt
  );
endinterface

// File: rtl/can_bit_timing_edge_sync.sv
// Brings the asynchronous CAN RX pin into the clk domain and flags falling edges.
// Ports: clk, reset (async, active-high), rx (raw pin) -> rx_s (synchronized level),
//        fall_edge (1-clk pulse, 2 clk after rx falls).
module can_edge_sync
  import can_bit_timing_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);

  logic rx_meta;
  logic rx_d;

  // All stages reset recessive so releasing reset on an idle bus is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= RECESSIVE;
      rx_s    <= RECESSIVE;
      rx_d    <= RECESSIVE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall_edge = is_fall(rx_d, rx_s);

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing unit: splits each bit into SYNC/TSEG1/TSEG2 time quanta, emits the
// sample-point strobe and the sampled bit, hard-syncs on SOF and resyncs (SJW-limited).
// Ports: clk, reset (async, active-high), bus (master: rx, hard_sync_en in;
//        sp, rx_bit, bit_start, resync_evt out -- all outputs registered).
module can_bit_timing
  import can_bit_timing_pkg::*;
#(
  parameter int BRP   = 4,
  parameter int TSEG1 = 7,
  parameter int TSEG2 = 2,
  parameter int SJW   = 1,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  can_bit_timing_if.master     bus
);

  localparam logic [CNT_W-1:0] BRP_LAST = CNT_W'(BRP - 1);
  localparam logic [CNT_W-1:0] TSEG1_Q  = CNT_W'(TSEG1);
  localparam logic [CNT_W-1:0] TSEG2_Q  = CNT_W'(TSEG2);
  localparam logic [CNT_W-1:0] SJW_Q    = CNT_W'(SJW);

  function automatic logic [CNT_W-1:0] sat_min(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic rx_s;
  logic fall_edge;

  can_edge_sync u_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus.rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  can_seg_t         seg;
  logic [CNT_W-1:0] pre;
  logic [CNT_W-1:0] tq_cnt;
  logic [CNT_W-1:0] ext;
  logic [CNT_W-1:0] shr;
  logic             sync_done;

  logic             sp_r;
  logic             rx_bit_r;
  logic             bit_start_r;
  logic [1:0]       resync_evt_r;

  logic             tq_tick;
  logic [CNT_W-1:0] seg1_len;
  logic [CNT_W-1:0] seg2_len;
  logic             last1;
  logic             last2;
  logic             hard_sync;
  logic             resync;
  logic [CNT_W-1:0] err_late;
  logic [CNT_W-1:0] err_early;

  assign tq_tick  = (pre == BRP_LAST);
  assign seg1_len = TSEG1_Q + ext;
  assign seg2_len = TSEG2_Q - shr;
  // ">=" rather than "==" so a segment shortened below the current count still ends.
  assign last1    = (tq_cnt >= seg1_len - 1'b1);
  assign last2    = (tq_cnt >= seg2_len - 1'b1);

  assign hard_sync = fall_edge && bus.hard_sync_en;
  assign resync    = fall_edge && !bus.hard_sync_en && !sync_done;

  // Phase errors in tq; tq_cnt is bounded by the segment length so neither wraps.
  assign err_late  = tq_cnt + 1'b1;
  assign err_early = TSEG2_Q - tq_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg          <= SEG_SYNC;
      pre          <= '0;
      tq_cnt       <= '0;
      ext          <= '0;
      shr          <= '0;
      sync_done    <= 1'b0;
      sp_r         <= 1'b0;
      rx_bit_r     <= RECESSIVE;
      bit_start_r  <= 1'b0;
      resync_evt_r <= RESYNC_NONE;
    end else begin
      sp_r         <= 1'b0;
      bit_start_r  <= 1'b0;
      resync_evt_r <= RESYNC_NONE;
      pre          <= tq_tick ? '0 : pre + 1'b1;

      // Nominal segment sequencing. Sync events below are evaluated against the
      // same (old) segment and override these assignments where they apply.
      if (tq_tick) begin
        case (seg)
          SEG_SYNC: begin
            seg    <= SEG_TSEG1;
            tq_cnt <= '0;
          end
          SEG_TSEG1: begin
            if (last1) begin
              sp_r      <= 1'b1;
              // An edge in this very cycle means rx_s already holds the new level;
              // the bit value is the level before that edge, which is recessive.
              rx_bit_r  <= fall_edge ? RECESSIVE : rx_s;
              seg       <= SEG_TSEG2;
              tq_cnt    <= '0;
              ext       <= '0;
              sync_done <= 1'b0;
            end else begin
              tq_cnt <= tq_cnt + 1'b1;
            end
          end
          SEG_TSEG2: begin
            if (last2) begin
              seg         <= SEG_SYNC;
              tq_cnt      <= '0;
              shr         <= '0;
              bit_start_r <= 1'b1;
            end else begin
              tq_cnt <= tq_cnt + 1'b1;
            end
          end
          default: begin
            seg    <= SEG_SYNC;
            tq_cnt <= '0;
          end
        endcase
      end

      if (hard_sync) begin
        // The edge cycle stands in for SYNC, so timing restarts straight in TSEG1.
        pre          <= '0;
        tq_cnt       <= '0;
        seg          <= SEG_TSEG1;
        ext          <= '0;
        shr          <= '0;
        sync_done    <= 1'b1;
        sp_r         <= 1'b0;
        rx_bit_r     <= rx_bit_r;
        bit_start_r  <= 1'b1;
        resync_evt_r <= RESYNC_HARD;
      end else if (resync) begin
        sync_done <= 1'b1;
        case (seg)
          SEG_TSEG1: begin
            resync_evt_r <= RESYNC_LATE;
            // If TSEG1 is ending this cycle the sample point is already taken;
            // lengthening would only leak into the next bit.
            if (!(tq_tick && last1)) begin
              ext <= sat_min(err_late, SJW_Q);
            end
          end
          SEG_TSEG2: begin
            resync_evt_r <= RESYNC_EARLY;
            if (err_early <= SJW_Q) begin
              // Close enough to the next bit: restart it at the edge.
              seg         <= SEG_TSEG1;
              tq_cnt      <= '0;
              pre         <= '0;
              shr         <= '0;
              bit_start_r <= 1'b1;
            end else begin
              shr <= SJW_Q;
            end
          end
          default: ;  // SYNC: edge is where it should be, phase error 0
        endcase
      end
    end
  end

  assign bus.sp         = sp_r;
  assign bus.rx_bit     = rx_bit_r;
  assign bus.bit_start  = bit_start_r;
  assign bus.resync_evt = resync_evt_r;

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: expected strobe/event cycles are queued when
// stimulus is scheduled and compared as the DUT produces them.
module tb_can_bit_timing;
  import can_bit_timing_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  int   strict_from;

  can_bit_timing_if bus ();

  can_bit_timing dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic b; }       sp_exp_t;
  typedef struct { int c; logic [1:0] e; } ev_exp_t;

  sp_exp_t sp_q[$];
  int      bs_q[$];
  ev_exp_t ev_q[$];

  task automatic push_sp(input int c, input logic b);
    sp_exp_t x;
    x.c = c; x.b = b;
    sp_q.push_back(x);
  endtask

  task automatic push_bs(input int c);
    bs_q.push_back(c);
  endtask

  task automatic push_ev(input int c, input logic [1:0] e);
    ev_exp_t x;
    x.c = c; x.e = e;
    ev_q.push_back(x);
  endtask

  // Wait for the falling clock edge of cycle c (no-op if already there).
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every strobe the DUT produces must match the head of its queue.
  int         m_c;
  logic       m_b;
  logic [1:0] m_e;
  always @(negedge clk) begin
    if (!reset && cyc >= strict_from) begin
      if (bus.sp) begin
        m_c = -1; m_b = 1'bx;
        if (sp_q.size() != 0) begin
          m_c = sp_q[0].c; m_b = sp_q[0].b;
          void'(sp_q.pop_front());
        end
        checks++;
        assert (cyc === m_c) else begin
          failures++; $error("FAIL sp_cycle observed=%0d expected=%0d", cyc, m_c);
        end
        checks++;
        assert (bus.rx_bit === m_b) else begin
          failures++; $error("FAIL rx_bit@%0d observed=%b expected=%b", cyc, bus.rx_bit, m_b);
        end
      end
      if (bus.bit_start) begin
        m_c = -1;
        if (bs_q.size() != 0) m_c = bs_q.pop_front();
        checks++;
        assert (cyc === m_c) else begin
          failures++; $error("FAIL bit_start_cycle observed=%0d expected=%0d", cyc, m_c);
        end
      end
      if (bus.resync_evt !== RESYNC_NONE) begin
        m_c = -1; m_e = 2'bxx;
        if (ev_q.size() != 0) begin
          m_c = ev_q[0].c; m_e = ev_q[0].e;
          void'(ev_q.pop_front());
        end
        checks++;
        assert (cyc === m_c) else begin
          failures++; $error("FAIL resync_cycle observed=%0d expected=%0d", cyc, m_c);
        end
        checks++;
        assert (bus.resync_evt === m_e) else begin
          failures++; $error("FAIL resync_evt@%0d observed=%b expected=%b", cyc, bus.resync_evt, m_e);
        end
      end
    end
  end

  task automatic check_drained(input string tag);
    checks++;
    assert (sp_q.size() === 0) else begin
      failures++; $error("FAIL %s sp_pending observed=%0d expected=0", tag, sp_q.size());
    end
    checks++;
    assert (bs_q.size() === 0) else begin
      failures++; $error("FAIL %s bit_start_pending observed=%0d expected=0", tag, bs_q.size());
    end
    checks++;
    assert (ev_q.size() === 0) else begin
      failures++; $error("FAIL %s resync_pending observed=%0d expected=0", tag, ev_q.size());
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert (bus.sp === 1'b0) else begin
      failures++; $error("FAIL %s sp observed=%b expected=0", tag, bus.sp);
    end
    checks++;
    assert (bus.rx_bit === 1'b1) else begin
      failures++; $error("FAIL %s rx_bit observed=%b expected=1", tag, bus.rx_bit);
    end
    checks++;
    assert (bus.bit_start === 1'b0) else begin
      failures++; $error("FAIL %s bit_start observed=%b expected=0", tag, bus.bit_start);
    end
    checks++;
    assert (bus.resync_evt === RESYNC_NONE) else begin
      failures++; $error("FAIL %s resync_evt observed=%b expected=00", tag, bus.resync_evt);
    end
    checks++;
    assert (dut.seg === SEG_SYNC) else begin
      failures++; $error("FAIL %s seg observed=%0d expected=%0d", tag, dut.seg, SEG_SYNC);
    end
  endtask

  int t;
  int u;

  initial begin
    checks = 0; failures = 0;
    strict_from = 32'h3fff_ffff;
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.hard_sync_en = 1'b0;

    repeat (3) @(negedge clk);
    #1 check_reset_state("reset_init");
    @(negedge clk) reset = 1'b0;
    bus.hard_sync_en = 1'b1;
    repeat (20) @(negedge clk);

    // rx driven at the falling edge of cycle k is acted on at the rising edge of k+3,
    // so registered outputs for that edge appear in cycle t = k+3.
    t = cyc + 3;
    // case 1: hard sync, sp 28 later, then 40-clk free run
    push_bs(t);       push_ev(t, RESYNC_HARD);  push_sp(t + 28, 1'b0);
    push_bs(t + 36);  push_sp(t + 68, 1'b0);
    // case 2: rx returns recessive, no resync on the rising edge
    push_bs(t + 76);  push_sp(t + 108, 1'b1);
    push_bs(t + 116); push_sp(t + 148, 1'b1);
    // case 3: late edge in TSEG1 (tq 2) -> sp 44 after previous
    push_bs(t + 156); push_ev(t + 170, RESYNC_LATE); push_sp(t + 192, 1'b0);
    push_bs(t + 200); push_sp(t + 232, 1'b1);
    // case 4a: early edge at TSEG2 tq 0 -> TSEG2 shortened, sp 36 after previous
    push_ev(t + 234, RESYNC_EARLY); push_bs(t + 236); push_sp(t + 268, 1'b1);
    // case 4b: early edge at TSEG2 tq 1 -> bit restarts at the edge
    push_bs(t + 274); push_ev(t + 274, RESYNC_EARLY); push_sp(t + 302, 1'b0);
    // case 5: two falling edges in one bit, only the first resyncs
    push_bs(t + 310); push_ev(t + 316, RESYNC_LATE); push_sp(t + 346, 1'b0);
    push_bs(t + 354);

    strict_from = t;
    bus.rx = 1'b0;
    at(t);       bus.hard_sync_en = 1'b0;
    at(t + 80);  bus.rx = 1'b1;
    at(t + 167); bus.rx = 1'b0;
    at(t + 210); bus.rx = 1'b1;
    at(t + 231); bus.rx = 1'b0;
    at(t + 250); bus.rx = 1'b1;
    at(t + 271); bus.rx = 1'b0;
    at(t + 304); bus.rx = 1'b1;
    at(t + 313); bus.rx = 1'b0;
    at(t + 318); bus.rx = 1'b1;
    at(t + 321); bus.rx = 1'b0;

    // case 6: reset in the middle of TSEG1
    at(t + 365);
    check_drained("before_reset");
    strict_from = 32'h3fff_ffff;
    reset = 1'b1;
    #1 check_reset_state("reset_mid_bit");
    bus.rx = 1'b1;
    bus.hard_sync_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    u = cyc + 3;
    push_bs(u);      push_ev(u, RESYNC_HARD); push_sp(u + 28, 1'b0);
    push_bs(u + 36); push_sp(u + 68, 1'b0);
    strict_from = u;
    bus.rx = 1'b0;
    at(u);      bus.hard_sync_en = 1'b0;
    at(u + 75);
    check_drained("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
